wb_config_regs: RTL
===================

# wb_config_regs

Parametrised bank of NUM_REGS configuration/status registers behind a Wishbone classic slave port, the successor to the single-word `register_rw` storage cell. Each register has its own reset value and access mode (read-write, read-only, write-1-to-clear, self-clearing pulse) with per-byte write enables. It sits between the Wishbone bus and the HyperRAM controller core, exposing controller settings and capturing status flags.

## Interface
- NUM_REGS, 4: number of registers, at least 1.
- ADDR_W, 2: word-address width; requires 2^ADDR_W >= NUM_REGS.
- WIDTH, 32: register width; a multiple of 8.
- DEFAULT_VALUES, 0: flat NUM_REGS*WIDTH vector; register i resets to slice [i*WIDTH +: WIDTH].
- MODES, 0: flat 2*NUM_REGS vector; register i uses slice [2i +: 2]. 00 = RW, 01 = RO, 10 = W1C, 11 = W1P.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  reset; asynchronous assertion, active-low.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_adr_i  in  ADDR_W  word address.
- wb_dat_i  in  WIDTH  write data.
- wb_sel_i  in  WIDTH/8  byte enables.
- wb_dat_o  out  WIDTH  registered read data.
- wb_ack_o  out  1  single-cycle acknowledge.
- hw_in  in  NUM_REGS*WIDTH  RO: live value. W1C: set bits. Ignored for RW and W1P.
- regs_out  out  NUM_REGS*WIDTH  current register contents; for RO registers, a passthrough of hw_in.
- wr_pulse  out  NUM_REGS  one-cycle strobe on each accepted write to register i.

## Operation
- Accept condition: wb_cyc_i & wb_stb_i & !wb_ack_o at a rising edge.
- Byte mask M: byte b of M = {8{wb_sel_i[b]}}.
- RW write: reg <= (reg & ~M) | (wb_dat_i & M).
- RO:
  - Writes are ignored.
  - A read returns hw_in sampled at the accept edge.
- W1C:
  - Every cycle: reg <= (reg & ~C) | S, where S = hw_in slice and C = wb_dat_i & M on an accepted write, else 0.
  - A hardware set wins over a simultaneous clear of the same bit.
- W1P:
  - Bits written 1 (under M) are high for exactly the next cycle, then return to 0.
  - Bits written 0 stay 0.
  - DEFAULT_VALUES is ignored for W1P; these registers reset to 0.
- Read data: wb_dat_o <= register value before the accept edge.
  - W1C: pre-clear value.
  - W1P: 0, unless a pulse is in flight.
- Out of range (wb_adr_i >= NUM_REGS):
  - Still acknowledged.
  - Reads return 0.
  - Writes have no effect and produce no wr_pulse.
- wr_pulse[i] fires for an in-range accepted write to register i in any mode, including RO and including wb_sel_i = 0.
- wb_sel_i has no effect on reads; the full word is returned.

## Timing
- Latency: ack is high in the cycle after the accept edge, for exactly one cycle.
- Write data, wb_dat_o and wr_pulse all update on the accept edge.
- Throughput: at most one transaction every 2 cycles, because a request held across the ack cycle is not re-accepted.
- Master rules:
  - The master holds wb_stb_i until it sees the ack.
  - Dropping wb_cyc_i or wb_stb_i after the accept edge does not cancel the transaction; the ack still occurs.
- Reset (rst low), applied asynchronously:
  - Stored registers: RW and W1C take DEFAULT_VALUES; W1P goes to 0.
  - wb_ack_o = 0, wb_dat_o = 0, wr_pulse = 0.
- Reset mid-transaction:
  - A pending ack is dropped and the transaction is lost.
  - A write completes only if its accept edge occurred before reset assertion.
- After rst rises, the first accept is possible at the next rising edge.

## Test plan
- Reset: with DEFAULT_VALUES reg0 = 0x1234_5678, assert rst low mid-cycle -> regs_out slice 0 = 0x1234_5678 immediately, ack = 0; a subsequent read of addr 0 -> 0x1234_5678 with ack one cycle after accept.
- Byte write, RW reg0 = 0x1234_5678: write 0xAABB_CCDD with sel = 0b0101 -> reg0 = 0x12BB_56DD; wr_pulse[0] high for exactly 1 cycle.
- W1C reg2 = 0x0000_00F0: write 0x30 with sel = 0xF -> reg2 = 0xC0. In the same cycle as a clear of bit 7, drive hw_in bit 7 = 1 -> bit 7 stays 1.
- W1P reg3: write 0x5 -> regs_out slice 3 = 0x5 for one cycle, then 0; a read afterwards returns 0.
- RO reg1, hw_in = 0xDEAD_BEEF:
  - A read returns 0xDEAD_BEEF.
  - A write of 0 leaves regs_out unchanged, and wr_pulse[1] still pulses.
- Out of range: NUM_REGS = 3, ADDR_W = 2, address 3 -> ack after 1 cycle, read data 0, no wr_pulse. A request with stb held high continuously -> acks on alternate cycles only.

Source files
------------

// File: rtl/wb_config_regs_if.sv
// Wishbone classic bus bundle for the configuration register bank.
// The master modport drives requests; the slave modport returns data/ack.
interface wb_config_regs_if #(
    parameter int ADDR_W = 2,
    parameter int WIDTH  = 32
) ();
    logic                 wb_cyc_i;
    logic                 wb_stb_i;
    logic                 wb_we_i;
    logic [ADDR_W-1:0]    wb_adr_i;
    logic [WIDTH-1:0]     wb_dat_i;
    logic [WIDTH/8-1:0]   wb_sel_i;
    logic [WIDTH-1:0]     wb_dat_o;
    logic                 wb_ack_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );
endinterface

// File: rtl/wb_config_regs.sv
// Bank of NUM_REGS configuration/status registers behind a Wishbone classic
// slave. Each register has its own reset value and access mode:
// 00 read-write, 01 read-only (live hw_in), 10 write-1-to-clear with hardware
// set, 11 self-clearing write-1 pulse. Writes honour per-byte enables.
module wb_config_regs #(
    parameter int                          NUM_REGS       = 4,
    parameter int                          ADDR_W         = 2,
    parameter int                          WIDTH          = 32,
    parameter logic [NUM_REGS*WIDTH-1:0]   DEFAULT_VALUES = {(NUM_REGS*WIDTH){1'b0}},
    parameter logic [2*NUM_REGS-1:0]       MODES          = {(2*NUM_REGS){1'b0}}
) (
    input  logic                          clk,
    input  logic                          rst,
    wb_config_regs_if.slave               wb,
    input  logic [NUM_REGS*WIDTH-1:0]     hw_in,
    output logic [NUM_REGS*WIDTH-1:0]     regs_out,
    output logic [NUM_REGS-1:0]           wr_pulse
);

    localparam int              NBYTES     = WIDTH / 8;
    localparam logic [1:0]      MODE_RW    = 2'b00;
    localparam logic [1:0]      MODE_RO    = 2'b01;
    localparam logic [1:0]      MODE_W1C   = 2'b10;
    localparam logic [1:0]      MODE_W1P   = 2'b11;
    // One extra bit so the range compare also works when NUM_REGS == 2^ADDR_W.
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    // Expand per-byte enables into a bit mask.
    function automatic logic [WIDTH-1:0] byte_mask(input logic [NBYTES-1:0] sel);
        logic [WIDTH-1:0] m;
        m = {WIDTH{1'b0}};
        for (int b = 0; b < NBYTES; b++) begin
            m[b*8 +: 8] = {8{sel[b]}};
        end
        return m;
    endfunction

    // Reset value of a stored register; pulse and read-only registers start at zero.
    function automatic logic [WIDTH-1:0] reset_val(input int idx);
        logic [WIDTH-1:0] v;
        case (MODES[2*idx +: 2])
            MODE_RW:  v = DEFAULT_VALUES[idx*WIDTH +: WIDTH];
            MODE_W1C: v = DEFAULT_VALUES[idx*WIDTH +: WIDTH];
            MODE_RO:  v = {WIDTH{1'b0}};
            MODE_W1P: v = {WIDTH{1'b0}};
            default:  v = {WIDTH{1'b0}};
        endcase
        return v;
    endfunction

    logic                 accept_s;
    logic                 in_range_s;
    logic [WIDTH-1:0]     mask_s;
    logic [WIDTH-1:0]     wdata_m_s;
    logic [NUM_REGS-1:0]  adr_hit_s;
    logic [NUM_REGS-1:0]  wr_hit_s;
    logic [WIDTH-1:0]     rd_data_s;
    logic [WIDTH-1:0]     cur_s     [NUM_REGS];
    logic [WIDTH-1:0]     reg_nxt_s [NUM_REGS];

    logic [WIDTH-1:0]     reg_r     [NUM_REGS];
    logic                 ack_r;
    logic [WIDTH-1:0]     dat_r;
    logic [NUM_REGS-1:0]  pulse_r;

    // Request decode, per-register next state and the read-data mux.
    always_comb begin
        // A request still held during its own ack cycle must not be taken twice.
        accept_s   = wb.wb_cyc_i & wb.wb_stb_i & ~ack_r;
        in_range_s = ({1'b0, wb.wb_adr_i} < NUM_REGS_L);
        mask_s     = byte_mask(wb.wb_sel_i);
        wdata_m_s  = wb.wb_dat_i & mask_s;
        adr_hit_s  = {NUM_REGS{1'b0}};
        wr_hit_s   = {NUM_REGS{1'b0}};
        rd_data_s  = {WIDTH{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_nxt_s[i] = reg_r[i];
            cur_s[i]     = reg_r[i];
            if (in_range_s && (wb.wb_adr_i == ADDR_W'(i))) begin
                adr_hit_s[i] = 1'b1;
            end else begin
                adr_hit_s[i] = 1'b0;
            end
            wr_hit_s[i] = accept_s & wb.wb_we_i & adr_hit_s[i];

            case (MODES[2*i +: 2])
                MODE_RW: begin
                    reg_nxt_s[i] = wr_hit_s[i] ? ((reg_r[i] & ~mask_s) | wdata_m_s) : reg_r[i];
                    cur_s[i]     = reg_r[i];
                end
                MODE_RO: begin
                    reg_nxt_s[i] = {WIDTH{1'b0}};
                    cur_s[i]     = hw_in[i*WIDTH +: WIDTH];
                end
                MODE_W1C: begin
                    // OR-ing the set term last lets a hardware set beat a clear.
                    reg_nxt_s[i] = (reg_r[i] & ~(wr_hit_s[i] ? wdata_m_s : {WIDTH{1'b0}}))
                                   | hw_in[i*WIDTH +: WIDTH];
                    cur_s[i]     = reg_r[i];
                end
                MODE_W1P: begin
                    reg_nxt_s[i] = wr_hit_s[i] ? wdata_m_s : {WIDTH{1'b0}};
                    cur_s[i]     = reg_r[i];
                end
                default: begin
                    reg_nxt_s[i] = reg_r[i];
                    cur_s[i]     = reg_r[i];
                end
            endcase

            rd_data_s = rd_data_s | (cur_s[i] & {WIDTH{adr_hit_s[i]}});
        end
    end

    // Flatten the visible register values onto the output bus.
    always_comb begin
        regs_out = {(NUM_REGS*WIDTH){1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_out[i*WIDTH +: WIDTH] = cur_s[i];
        end
    end

    // Register storage, ack, read data and write strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_r[i] <= reset_val(i);
            end
            ack_r   <= 1'b0;
            dat_r   <= {WIDTH{1'b0}};
            pulse_r <= {NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_r[i] <= reg_nxt_s[i];
            end
            ack_r   <= accept_s;
            pulse_r <= wr_hit_s;
            if (accept_s) begin
                dat_r <= rd_data_s;
            end else begin
                dat_r <= dat_r;
            end
        end
    end

    assign wb.wb_ack_o = ack_r;
    assign wb.wb_dat_o = dat_r;
    assign wr_pulse    = pulse_r;

endmodule
